// File: rtl/riscv_sb_pkg.sv
// Shared definitions for the register scoreboard: stall-cause encodings and
// default execution-unit latencies.
package riscv_sb_pkg;

    typedef enum logic [1:0] {
        SB_CAUSE_NONE = 2'd0,
        SB_CAUSE_RAW  = 2'd1,
        SB_CAUSE_WAW  = 2'd2,
        SB_CAUSE_SLOT = 2'd3
    } sb_cause_e;

    localparam int SB_MAX_LAT_DFLT = 8;

    localparam logic [3:0] LAT_ALU  = 4'd1;
    localparam logic [3:0] LAT_LOAD = 4'd2;
    localparam logic [3:0] LAT_MUL  = 4'd3;
    localparam logic [3:0] LAT_DIV  = 4'(SB_MAX_LAT_DFLT);

endpackage

// File: rtl/sb_slot_ring.sv
// Writeback-port reservation vector: bit j set means a writeback lands j
// cycles from now. Shifts down every cycle; reserve/release act on the next state.
module sb_slot_ring #(
    parameter int MAX_LAT   = 8,
    parameter int LAT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 reserve,
    input  logic [LAT_WIDTH-1:0] reserve_lat,
    input  logic                 release_en,
    input  logic [LAT_WIDTH-1:0] release_lat,
    input  logic [LAT_WIDTH-1:0] check_lat,
    output logic                 conflict
);

    logic [MAX_LAT:1] slot_r;
    logic [MAX_LAT:1] slot_nxt_s;
    logic [MAX_LAT:1] rel_mask_s;
    logic [MAX_LAT:1] res_mask_s;

    // Reservation made one cycle ago for latency L now sits at index L-1.
    always_comb begin
        rel_mask_s = '0;
        res_mask_s = '0;
        for (int j = 1; j <= MAX_LAT; j++) begin
            rel_mask_s[j] = release_en && (release_lat == LAT_WIDTH'(j + 1));
            res_mask_s[j] = reserve && (reserve_lat == LAT_WIDTH'(j + 1));
        end
        slot_nxt_s = ((slot_r & ~rel_mask_s) >> 1) | res_mask_s;
        conflict   = slot_r[check_lat];
    end

    // Slot vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r <= '0;
        end else begin
            slot_r <= slot_nxt_s;
        end
    end

endmodule

// File: rtl/riscv_scoreboard.sv
// Variable-latency register scoreboard beside decode: RAW/WAW/writeback-slot
// stalls plus kill of the youngest issue. Optional stall counters: RISCV_SB_STATS_EN.
module riscv_scoreboard
    import riscv_sb_pkg::*;
#(
    parameter int MP_ADDR_WIDTH = 5,
    parameter int MP_MAX_LAT    = 8,
    parameter int MP_LAT_WIDTH  = 4
) (
    input  logic                        iclk,
    input  logic                        irst_n,
    input  logic                        ivalid_d,
    input  logic [MP_ADDR_WIDTH-1:0]    irs1_d,
    input  logic [MP_ADDR_WIDTH-1:0]    irs2_d,
    input  logic                        irs1_used_d,
    input  logic                        irs2_used_d,
    input  logic [MP_ADDR_WIDTH-1:0]    ird_d,
    input  logic                        ireg_wr_d,
    input  logic [MP_LAT_WIDTH-1:0]     ilat_d,
    input  logic                        ikill_e,
    output logic                        ostall_d,
    output logic                        oissue_d,
    output logic [1:0]                  ocause_d,
    output logic [2**MP_ADDR_WIDTH-1:0] obusy
`ifdef RISCV_SB_STATS_EN
    ,
    output logic [31:0]                 ostat_raw,
    output logic [31:0]                 ostat_waw,
    output logic [31:0]                 ostat_slot
`endif
);

    localparam int NREG = 2**MP_ADDR_WIDTH;
    localparam logic [MP_LAT_WIDTH-1:0] MAX_LAT_C = MP_LAT_WIDTH'(MP_MAX_LAT);

    logic [MP_LAT_WIDTH-1:0]  cnt_r     [NREG];
    logic [MP_LAT_WIDTH-1:0]  cnt_nxt_s [NREG];
    logic [MP_LAT_WIDTH-1:0]  lat_s;
    logic                     wr_s, raw_s, waw_s, slot_hit_s, slot_conf_s;
    logic                     stall_s, issue_s, alloc_s, kill_s;
    sb_cause_e                cause_s;
    logic                     rec_valid_r;
    logic [MP_ADDR_WIDTH-1:0] rec_rd_r;
    logic [MP_LAT_WIDTH-1:0]  rec_lat_r;

    // Out-of-range latencies fall back to the slowest unit.
    always_comb begin
        if ((ilat_d == '0) || (ilat_d > MAX_LAT_C)) begin
            lat_s = MAX_LAT_C;
        end else begin
            lat_s = ilat_d;
        end
    end

    // Hazard detection, cause priority and issue/kill qualification.
    always_comb begin
        wr_s        = ireg_wr_d && (ird_d != '0);
        raw_s       = (irs1_used_d && (irs1_d != '0) && (cnt_r[irs1_d] != '0)) ||
                      (irs2_used_d && (irs2_d != '0) && (cnt_r[irs2_d] != '0));
        waw_s       = wr_s && (cnt_r[ird_d] != '0);
        slot_conf_s = wr_s && slot_hit_s;
        if (!ivalid_d) begin
            cause_s = SB_CAUSE_NONE;
        end else if (raw_s) begin
            cause_s = SB_CAUSE_RAW;
        end else if (waw_s) begin
            cause_s = SB_CAUSE_WAW;
        end else if (slot_conf_s) begin
            cause_s = SB_CAUSE_SLOT;
        end else begin
            cause_s = SB_CAUSE_NONE;
        end
        stall_s = (cause_s != SB_CAUSE_NONE);
        issue_s = ivalid_d && !stall_s && !ikill_e;
        alloc_s = issue_s && wr_s;
        kill_s  = ikill_e && rec_valid_r;
    end

    // Counter next state: kill beats the ordinary decrement.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            if (r == 0) begin
                cnt_nxt_s[r] = '0;
            end else if (kill_s && (rec_rd_r == MP_ADDR_WIDTH'(r))) begin
                cnt_nxt_s[r] = '0;
            end else if (alloc_s && (ird_d == MP_ADDR_WIDTH'(r))) begin
                cnt_nxt_s[r] = lat_s - MP_LAT_WIDTH'(1);
            end else if (cnt_r[r] != '0) begin
                cnt_nxt_s[r] = cnt_r[r] - MP_LAT_WIDTH'(1);
            end else begin
                cnt_nxt_s[r] = cnt_r[r];
            end
        end
    end

    // Per-register pending counters.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= cnt_nxt_s[r];
            end
        end
    end

    // Record of the most recent allocating issue, live for one cycle only.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            rec_valid_r <= 1'b0;
            rec_rd_r    <= '0;
            rec_lat_r   <= '0;
        end else begin
            rec_valid_r <= alloc_s;
            if (alloc_s) begin
                rec_rd_r  <= ird_d;
                rec_lat_r <= lat_s;
            end
        end
    end

    sb_slot_ring #(
        .MAX_LAT   (MP_MAX_LAT),
        .LAT_WIDTH (MP_LAT_WIDTH)
    ) u_slot_ring (
        .clk         (iclk),
        .rst_n       (irst_n),
        .reserve     (alloc_s),
        .reserve_lat (lat_s),
        .release_en  (kill_s),
        .release_lat (rec_lat_r),
        .check_lat   (lat_s),
        .conflict    (slot_hit_s)
    );

    // Busy view straight from the counter registers.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            obusy[r] = (cnt_r[r] != '0);
        end
    end

    assign ostall_d = stall_s;
    assign oissue_d = issue_s;
    assign ocause_d = cause_s;

`ifdef RISCV_SB_STATS_EN
    // Saturating per-cause stall-cycle counters.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            ostat_raw  <= 32'd0;
            ostat_waw  <= 32'd0;
            ostat_slot <= 32'd0;
        end else begin
            if ((cause_s == SB_CAUSE_RAW) && (ostat_raw != 32'hFFFF_FFFF)) begin
                ostat_raw <= ostat_raw + 32'd1;
            end
            if ((cause_s == SB_CAUSE_WAW) && (ostat_waw != 32'hFFFF_FFFF)) begin
                ostat_waw <= ostat_waw + 32'd1;
            end
            if ((cause_s == SB_CAUSE_SLOT) && (ostat_slot != 32'hFFFF_FFFF)) begin
                ostat_slot <= ostat_slot + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_scoreboard.sv
// Directed self-checking bench for riscv_scoreboard (default parameters).
module tb_riscv_scoreboard;

    logic        iclk;
    logic        irst_n;
    logic        ivalid_d;
    logic [4:0]  irs1_d, irs2_d, ird_d;
    logic        irs1_used_d, irs2_used_d, ireg_wr_d, ikill_e;
    logic [3:0]  ilat_d;
    logic        ostall_d, oissue_d;
    logic [1:0]  ocause_d;
    logic [31:0] obusy;
`ifdef RISCV_SB_STATS_EN
    logic [31:0] ostat_raw, ostat_waw, ostat_slot;
`endif

    int checks = 0;
    int errors = 0;

    riscv_scoreboard dut (
        .iclk        (iclk),
        .irst_n      (irst_n),
        .ivalid_d    (ivalid_d),
        .irs1_d      (irs1_d),
        .irs2_d      (irs2_d),
        .irs1_used_d (irs1_used_d),
        .irs2_used_d (irs2_used_d),
        .ird_d       (ird_d),
        .ireg_wr_d   (ireg_wr_d),
        .ilat_d      (ilat_d),
        .ikill_e     (ikill_e),
        .ostall_d    (ostall_d),
        .oissue_d    (oissue_d),
        .ocause_d    (ocause_d),
        .obusy       (obusy)
`ifdef RISCV_SB_STATS_EN
        ,
        .ostat_raw   (ostat_raw),
        .ostat_waw   (ostat_waw),
        .ostat_slot  (ostat_slot)
`endif
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Drive one decode cycle at the falling edge; outputs settle 1 time unit later.
    task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic [3:0] lat, input logic kill);
        @(negedge iclk);
        ivalid_d = v; irs1_d = rs1; irs1_used_d = u1; irs2_d = rs2; irs2_used_d = u2;
        ird_d = rd; ireg_wr_d = wr; ilat_d = lat; ikill_e = kill;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd1, 1'b0);
    endtask

    task automatic test_reset;
        irst_n = 1'b0;
        drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd1, 1'b0);
        checks++; if (obusy !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h want 0", obusy); end
        checks++; if (ostall_d !== 1'b0 || oissue_d !== 1'b0 || ocause_d !== 2'd0) begin
            errors++; $display("FAIL reset_out: stall=%b issue=%b cause=%0d want 0 0 0", ostall_d, oissue_d, ocause_d);
        end
        @(negedge iclk);
        irst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_raw;
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 4'd2, 1'b0);
        checks++; if (oissue_d !== 1'b1) begin errors++; $display("FAIL raw_load_issue: got %b want 1", oissue_d); end
        drv(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 4'd1, 1'b0);
        checks++; if (ostall_d !== 1'b1 || ocause_d !== 2'd1 || oissue_d !== 1'b0) begin
            errors++; $display("FAIL raw_stall: stall=%b cause=%0d issue=%b want 1 1 0", ostall_d, ocause_d, oissue_d);
        end
        checks++; if (obusy[5] !== 1'b1) begin errors++; $display("FAIL raw_busy_set: got %b want 1", obusy[5]); end
        drv(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 4'd1, 1'b0);
        checks++; if (oissue_d !== 1'b1 || ostall_d !== 1'b0 || ocause_d !== 2'd0) begin
            errors++; $display("FAIL raw_release: issue=%b stall=%b cause=%0d want 1 0 0", oissue_d, ostall_d, ocause_d);
        end
        checks++; if (obusy[5] !== 1'b0) begin errors++; $display("FAIL raw_busy_clr: got %b want 0", obusy[5]); end
        idle(3);
    endtask

    task automatic test_alu_x0;
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 4'd1, 1'b0);
        drv(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 4'd1, 1'b0);
        checks++; if (oissue_d !== 1'b1 || ostall_d !== 1'b0) begin
            errors++; $display("FAIL alu_no_stall: issue=%b stall=%b want 1 0", oissue_d, ostall_d);
        end
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'd3, 1'b0);
        checks++; if (oissue_d !== 1'b1) begin errors++; $display("FAIL x0_write_issue: got %b want 1", oissue_d); end
        drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd17, 1'b1, 4'd1, 1'b0);
        checks++; if (oissue_d !== 1'b1 || ostall_d !== 1'b0) begin
            errors++; $display("FAIL x0_reader: issue=%b stall=%b want 1 0", oissue_d, ostall_d);
        end
        checks++; if (obusy !== 32'd0) begin errors++; $display("FAIL x0_busy: got %h want 0", obusy); end
        idle(3);
    endtask

    task automatic test_waw;
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 4'd3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 4'd1, 1'b0);
            checks++; if (ostall_d !== 1'b1 || ocause_d !== 2'd2) begin
                errors++; $display("FAIL waw_stall%0d: stall=%b cause=%0d want 1 2", i, ostall_d, ocause_d);
            end
        end
        drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 4'd1, 1'b0);
        checks++; if (oissue_d !== 1'b1 || ocause_d !== 2'd0) begin
            errors++; $display("FAIL waw_issue: issue=%b cause=%0d want 1 0", oissue_d, ocause_d);
        end
        idle(4);
    endtask

    task automatic test_slot;
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 4'd3, 1'b0);
        drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 4'd2, 1'b0);
        checks++; if (ostall_d !== 1'b1 || ocause_d !== 2'd3 || oissue_d !== 1'b0) begin
            errors++; $display("FAIL slot_stall: stall=%b cause=%0d issue=%b want 1 3 0", ostall_d, ocause_d, oissue_d);
        end
        drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 4'd2, 1'b0);
        checks++; if (oissue_d !== 1'b1 || ostall_d !== 1'b0) begin
            errors++; $display("FAIL slot_issue: issue=%b stall=%b want 1 0", oissue_d, ostall_d);
        end
        idle(4);
    endtask

    task automatic test_kill;
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 4'd8, 1'b0);
        drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd19, 1'b1, 4'd1, 1'b1);
        checks++; if (oissue_d !== 1'b0 || ostall_d !== 1'b0) begin
            errors++; $display("FAIL kill_gate: issue=%b stall=%b want 0 0", oissue_d, ostall_d);
        end
        checks++; if (obusy[11] !== 1'b1) begin errors++; $display("FAIL kill_busy_before: got %b want 1", obusy[11]); end
        drv(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 4'd6, 1'b0);
        checks++; if (obusy[11] !== 1'b0) begin errors++; $display("FAIL kill_busy_after: got %b want 0", obusy[11]); end
        checks++; if (oissue_d !== 1'b1 || ostall_d !== 1'b0) begin
            errors++; $display("FAIL kill_reader: issue=%b stall=%b cause=%0d want 1 0", oissue_d, ostall_d, ocause_d);
        end
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd18, 1'b1, 4'd7, 1'b0);
        checks++; if (oissue_d !== 1'b1) begin errors++; $display("FAIL kill_l7: issue=%b cause=%0d want 1", oissue_d, ocause_d); end
        idle(10);
    endtask

    task automatic test_lat_norm(input logic [3:0] lat, input int exp_stalls);
        int  stalls;
        bit  done;
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, lat, 1'b0);
        stalls = 0;
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            drv(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd22, 1'b1, 4'd1, 1'b0);
            if (oissue_d === 1'b1) done = 1'b1;
            else stalls++;
        end
        checks++; if (!done || stalls != exp_stalls) begin
            errors++; $display("FAIL lat_norm_%0d: issued=%b stalls=%0d want 1 %0d", lat, done, stalls, exp_stalls);
        end
        idle(10);
    endtask

    task automatic test_reset_mid;
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 4'd8, 1'b0);
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 4'd8, 1'b0);
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd15, 1'b1, 4'd8, 1'b0);
        checks++; if (oissue_d !== 1'b1) begin errors++; $display("FAIL rst_pre_issue: got %b want 1", oissue_d); end
        @(negedge iclk);
        ivalid_d = 1'b0;
        #1;
        checks++; if (obusy[14:13] !== 2'b11) begin errors++; $display("FAIL rst_pre_busy: got %b want 11", obusy[14:13]); end
        #1 irst_n = 1'b0;
        #1;
        checks++; if (obusy !== 32'd0) begin errors++; $display("FAIL rst_mid_busy: got %h want 0", obusy); end
        @(negedge iclk);
        irst_n = 1'b1;
        drv(1'b1, 5'd13, 1'b1, 5'd14, 1'b1, 5'd21, 1'b1, 4'd1, 1'b0);
        checks++; if (oissue_d !== 1'b1 || ostall_d !== 1'b0) begin
            errors++; $display("FAIL rst_post_issue: issue=%b stall=%b want 1 0", oissue_d, ostall_d);
        end
        idle(2);
    endtask

    initial begin
        irst_n = 1'b0;
        ivalid_d = 1'b0; irs1_d = 5'd0; irs2_d = 5'd0; ird_d = 5'd0;
        irs1_used_d = 1'b0; irs2_used_d = 1'b0; ireg_wr_d = 1'b0;
        ilat_d = 4'd1; ikill_e = 1'b0;
        test_reset();
        test_raw();
        test_alu_x0();
        test_waw();
        test_slot();
        test_kill();
        test_lat_norm(4'd0, 7);
        test_lat_norm(4'd12, 7);
        test_lat_norm(4'd3, 2);
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_scoreboard.md
Name: riscv_scoreboard

Overview:
- Parametrised register scoreboard that generalises the pipeline hazard unit to execution units with variable latency (ALU 1, load 2, multiply/divide up to MP_MAX_LAT).
- Sits beside decode. Tracks per-register result availability and writeback-port reservations.
- Asserts stall on RAW, WAW or writeback-slot conflicts, and cancels the youngest issue when execute is flushed.

Parameters:
- MP_ADDR_WIDTH, 5, register index width; 2**MP_ADDR_WIDTH architectural registers.
- MP_MAX_LAT, 8, maximum result latency in cycles (>=2).
- MP_LAT_WIDTH, 4, latency field width; must hold MP_MAX_LAT.

Ports:
- iclk  in  1  clock.
- irst_n  in  1  asynchronous active-low reset.
- ivalid_d  in  1  decode holds a valid instruction.
- irs1_d  in  MP_ADDR_WIDTH  source 1 index.
- irs2_d  in  MP_ADDR_WIDTH  source 2 index.
- irs1_used_d  in  1  instruction reads rs1.
- irs2_used_d  in  1  instruction reads rs2.
- ird_d  in  MP_ADDR_WIDTH  destination index.
- ireg_wr_d  in  1  instruction writes rd.
- ilat_d  in  MP_LAT_WIDTH  result latency L, 1..MP_MAX_LAT.
- ikill_e  in  1  flush execute; cancels the issue of the previous cycle.
- ostall_d  out  1  hold fetch/decode this cycle (combinational).
- oissue_d  out  1  instruction issues this cycle (combinational).
- ocause_d  out  2  stall cause: 0 none, 1 RAW, 2 WAW, 3 writeback slot.
- obusy  out  2**MP_ADDR_WIDTH  per-register pending bit (registered view).

Behaviour:
- Reset (irst_n low, asynchronous): all counters 0, slot vector 0, last-issue record invalid. Outputs: obusy=0, ostall_d=0, oissue_d=0, ocause_d=0.
- Per-register counter cnt[r], MP_LAT_WIDTH bits. Busy means cnt[r]!=0. Register x0 is never busy, never allocated, never causes a stall.
- Issue at cycle t with latency L loads cnt[rd]=L-1. Every nonzero counter decrements by 1 each cycle.
- The result is usable by a consumer issuing at cycle t+L. L=1 never stalls the next instruction.
- RAW: stall if (irs1_used_d and cnt[rs1]!=0) or (irs2_used_d and cnt[rs2]!=0).
- WAW: stall if ireg_wr_d and rd!=0 and cnt[rd]!=0. At most one pending writer per register.
- Writeback slot: shift vector slot[MP_MAX_LAT:1]. slot[j] set means a writeback occurs j cycles from now; the vector shifts down by one each cycle.
  - An issue with ireg_wr_d conflicts if slot[L] is set.
  - An issue sets slot[L] in the next state, accounting for the same-cycle shift.
- Cause priority: RAW > WAW > slot. ostall_d = ivalid_d and any cause. With ivalid_d=0, ostall_d=0 and ocause_d=0.
- oissue_d = ivalid_d and not ostall_d and not ikill_e. No state changes when oissue_d=0.
- Kill: a last-issue record (valid, rd, L) is captured on every issue.
  - ikill_e in cycle t+1 with the record valid clears cnt[rd] and the corresponding slot bit, now slot[L-1].
  - The record is invalidated every cycle unless a new issue occurs.
  - Kill and decrement in the same cycle: kill wins.
- An instruction with ireg_wr_d=0 or rd=0 issues without allocating a counter or slot.
- ilat_d=0 or ilat_d>MP_MAX_LAT is treated as MP_MAX_LAT.
- obusy is derived from counter registers only; it carries no same-cycle issue effect.

Optional Feature:
- Macro RISCV_SB_STATS_EN.
- Defined: adds three 32-bit saturating outputs ostat_raw, ostat_waw, ostat_slot. Each increments once per stalled cycle of its cause. All reset to 0.
- Undefined: ports and counters are absent. Functional behaviour is identical.

Decomposition:
- Shared package riscv_sb_pkg holds:
  - stall-cause encodings SB_CAUSE_NONE/RAW/WAW/SLOT;
  - default latency constants LAT_ALU=1, LAT_LOAD=2, LAT_MUL=3, LAT_DIV=MP_MAX_LAT.
- One natural sub-module: sb_slot_ring, the writeback reservation shift vector with reserve/release/conflict ports.
- Counter array and stall logic stay in the top module.

Test Plan:
- Load x5 (L=2) at t, then add x6,x5,x1 at t+1 -> ostall_d=1 and ocause_d=1 for one cycle; issue at t+2. obusy[5] is 1 after t and 0 from t+2.
- ALU write x7 (L=1), then consumer of x7 next cycle -> no stall. Writing x0 with L=3 -> obusy stays 0 and a reader of x0 issues.
- Mul x8 (L=3) at t, then ALU write x8 at t+1 -> WAW: ocause_d=2 for 2 cycles; issue at t+3.
- Mul x9 (L=3) at t, load x10 (L=2) at t+1 -> both complete at t+3: ocause_d=3 and stall 1 cycle; issue at t+2.
- Div x11 (L=8) at t, ikill_e at t+1 -> obusy[11]=0 at t+2. A reader of x11 issues at t+2, and a later L=7 issue causes no slot conflict.
- Assert irst_n low mid-operation with 3 registers pending -> obusy=0 immediately; the first instruction after release issues with no stall.
